// File: rtl/l1_scaler_accum_pkg.sv
// Shared constants and helpers for the L1 scaler accumulator.
package l1_scaler_accum_pkg;

  localparam int SCAL_NUM_L1 = 20;
  localparam int SCAL_BITS   = 16;

  // Number of bits needed to address 'value' distinct items (minimum 1).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/l1_scaler_counter.sv
// One L1 channel: saturating event counter, sticky saturation flag and
// holding register loaded on latch.
module l1_scaler_counter #(
  parameter int SCALER_BITS = 16
) (
  input  logic                   sclk_i,
  input  logic                   rst_n_i,
  input  logic                   event_i,
  input  logic                   latch_i,
  output logic [SCALER_BITS-1:0] hold_o,
  output logic                   hsat_o
);

  localparam logic [SCALER_BITS-1:0] CNT_MAX = '1;

  logic [SCALER_BITS-1:0] cnt;
  logic [SCALER_BITS-1:0] cnt_nxt;
  logic                   sat;
  logic                   sat_nxt;

  // Count including this cycle's event, so a latch never drops the coincident event.
  always_comb begin
    cnt_nxt = cnt;
    if (event_i && (cnt != CNT_MAX)) cnt_nxt = cnt + 1'b1;
    sat_nxt = sat | (cnt_nxt == CNT_MAX);
  end

  // Counter/flag update; on latch the closing period moves into the holding register.
  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt    <= '0;
      sat    <= 1'b0;
      hold_o <= '0;
      hsat_o <= 1'b0;
    end else if (latch_i) begin
      hold_o <= cnt_nxt;
      hsat_o <= sat_nxt;
      cnt    <= '0;
      sat    <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sat    <= sat_nxt;
    end
  end

endmodule

// File: rtl/l1_scaler_accum.sv
// L1 scaler accumulator: per-channel counters, gate-period timer with
// external latch, and registered single-channel readback.
module l1_scaler_accum
  import l1_scaler_accum_pkg::*;
#(
  parameter int NUM_L1      = SCAL_NUM_L1,
  parameter int NUM_L1_BITS = clogb2(NUM_L1),
  parameter int SCALER_BITS = SCAL_BITS,
  parameter int PERIOD_BITS = 20
) (
  input  logic                   sclk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_L1-1:0]      scaler_i,
  input  logic                   sce_i,
  input  logic [PERIOD_BITS-1:0] period_i,
  input  logic                   ext_latch_i,
  input  logic [NUM_L1_BITS-1:0] rd_addr_i,
  input  logic                   rd_stb_i,
  output logic [SCALER_BITS-1:0] rd_data_o,
  output logic                   rd_sat_o,
  output logic                   rd_ack_o,
  output logic                   latch_o,
  output logic [7:0]             period_num_o
);

  logic [PERIOD_BITS-1:0] pcnt;
  logic [PERIOD_BITS-1:0] period_m1;
  logic                   auto_latch;
  logic                   latch;

  logic [SCALER_BITS-1:0] hold_w [NUM_L1];
  logic [NUM_L1-1:0]      hsat_w;
  logic [SCALER_BITS-1:0] sel_data;
  logic                   sel_sat;

  // Latch decision; >= lets a shrunk period close at the very next tick.
  always_comb begin
    period_m1  = period_i - 1'b1;
    auto_latch = sce_i && (period_i != '0) && (pcnt >= period_m1);
    latch      = auto_latch || ext_latch_i;
  end

  // Gate-period tick counter, restarted by any latch.
  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i)   pcnt <= '0;
    else if (latch) pcnt <= '0;
    else if (sce_i) pcnt <= pcnt + 1'b1;
  end

  // Latch pulse and period numbering.
  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      latch_o      <= 1'b0;
      period_num_o <= '0;
    end else begin
      latch_o <= latch;
      if (latch) period_num_o <= period_num_o + 1'b1;
    end
  end

  genvar gc;
  generate
    for (gc = 0; gc < NUM_L1; gc++) begin : g_chan
      l1_scaler_counter #(
        .SCALER_BITS (SCALER_BITS)
      ) u_cnt (
        .sclk_i  (sclk_i),
        .rst_n_i (rst_n_i),
        .event_i (scaler_i[gc]),
        .latch_i (latch),
        .hold_o  (hold_w[gc]),
        .hsat_o  (hsat_w[gc])
      );
    end
  endgenerate

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    sel_data = '0;
    sel_sat  = 1'b0;
    for (int i = 0; i < NUM_L1; i++) begin
      if (rd_addr_i == NUM_L1_BITS'(i)) begin
        sel_data = hold_w[i];
        sel_sat  = hsat_w[i];
      end
    end
  end

  // Registered readback; data holds between strobes, pre-latch value on collision.
  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_o <= '0;
      rd_sat_o  <= 1'b0;
      rd_ack_o  <= 1'b0;
    end else begin
      rd_ack_o <= rd_stb_i;
      if (rd_stb_i) begin
        rd_data_o <= sel_data;
        rd_sat_o  <= sel_sat;
      end
    end
  end

endmodule

// File: tb/tb_l1_scaler_accum.sv
// Scoreboard bench for l1_scaler_accum with a 4-bit counter build.
module tb_l1_scaler_accum;

  localparam int NL   = 20;
  localparam int AB   = 5;
  localparam int SB   = 4;
  localparam int PB   = 20;
  localparam int MAXV = (1 << SB) - 1;

  logic          sclk_i = 1'b0;
  logic          rst_n_i;
  logic [NL-1:0] scaler_i;
  logic          sce_i;
  logic [PB-1:0] period_i;
  logic          ext_latch_i;
  logic [AB-1:0] rd_addr_i;
  logic          rd_stb_i;
  logic [SB-1:0] rd_data_o;
  logic          rd_sat_o;
  logic          rd_ack_o;
  logic          latch_o;
  logic [7:0]    period_num_o;

  l1_scaler_accum #(
    .NUM_L1      (NL),
    .NUM_L1_BITS (AB),
    .SCALER_BITS (SB),
    .PERIOD_BITS (PB)
  ) dut (
    .sclk_i       (sclk_i),
    .rst_n_i      (rst_n_i),
    .scaler_i     (scaler_i),
    .sce_i        (sce_i),
    .period_i     (period_i),
    .ext_latch_i  (ext_latch_i),
    .rd_addr_i    (rd_addr_i),
    .rd_stb_i     (rd_stb_i),
    .rd_data_o    (rd_data_o),
    .rd_sat_o     (rd_sat_o),
    .rd_ack_o     (rd_ack_o),
    .latch_o      (latch_o),
    .period_num_o (period_num_o)
  );

  always #5 sclk_i = ~sclk_i;

  typedef struct { bit latch; int pnum; bit ack; } st_t;
  typedef struct { int data; bit sat; } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: raw event counts per period, capped only when latched.
  int cnt_m  [NL];
  int hold_m [NL];
  bit hsat_m [NL];
  int ticks_m;
  int pnum_m;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NL; c++) begin
      cnt_m[c] = 0; hold_m[c] = 0; hsat_m[c] = 0;
    end
    ticks_m = 0;
    pnum_m  = 0;
    st_q.delete();
    rd_q.delete();
  endtask

  // Drive one clock cycle of stimulus and record what the DUT must show after it.
  task automatic cyc(input logic [NL-1:0] sc, input bit sce, input int per,
                     input bit ext, input bit stb, input int addr);
    st_t st;
    rd_t rd;
    bit  do_latch;
    scaler_i    = sc;
    sce_i       = sce;
    period_i    = PB'(per);
    ext_latch_i = ext;
    rd_stb_i    = stb;
    rd_addr_i   = AB'(addr);
    if (stb) begin
      rd.data = (addr < NL) ? hold_m[addr] : 0;
      rd.sat  = (addr < NL) ? hsat_m[addr] : 1'b0;
      rd_q.push_back(rd);
    end
    for (int c = 0; c < NL; c++) if (sc[c]) cnt_m[c]++;
    do_latch = ext || (sce && per != 0 && ticks_m >= per - 1);
    if (do_latch) begin
      for (int c = 0; c < NL; c++) begin
        hold_m[c] = (cnt_m[c] > MAXV) ? MAXV : cnt_m[c];
        hsat_m[c] = (cnt_m[c] >= MAXV);
        cnt_m[c]  = 0;
      end
      ticks_m = 0;
      pnum_m  = (pnum_m + 1) % 256;
    end else if (sce) begin
      ticks_m++;
    end
    st.latch = do_latch;
    st.pnum  = pnum_m;
    st.ack   = stb;
    @(posedge sclk_i);
    st_q.push_back(st);
    #1;
  endtask

  // Monitor: compares each cycle's status and any returned read data.
  st_t st_mon;
  rd_t rd_mon;
  always @(negedge sclk_i) begin
    if (rst_n_i && st_q.size() > 0) begin
      st_mon = st_q.pop_front();
      chk("latch_o", int'(latch_o), int'(st_mon.latch));
      chk("period_num_o", int'(period_num_o), st_mon.pnum);
      chk("rd_ack_o", int'(rd_ack_o), int'(st_mon.ack));
      if (st_mon.ack) begin
        if (rd_q.size() == 0) begin
          chk("rd_queue_underflow", 1, 0);
        end else begin
          rd_mon = rd_q.pop_front();
          chk("rd_data_o", int'(rd_data_o), rd_mon.data);
          chk("rd_sat_o", int'(rd_sat_o), int'(rd_mon.sat));
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_data"}, int'(rd_data_o), 0);
    chk({tag, "_rd_sat"}, int'(rd_sat_o), 0);
    chk({tag, "_rd_ack"}, int'(rd_ack_o), 0);
    chk({tag, "_latch"}, int'(latch_o), 0);
    chk({tag, "_pnum"}, int'(period_num_o), 0);
  endtask

  task automatic zero_inputs();
    scaler_i = '0; sce_i = 0; period_i = '0; ext_latch_i = 0;
    rd_addr_i = '0; rd_stb_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL-1:0] r;
    int per;
    rst_n_i = 1'b0;
    zero_inputs();
    model_reset();
    #13;
    check_outputs_zero("reset");
    #9 rst_n_i = 1'b1;
    @(posedge sclk_i); #1;

    // Fixed period: period 10, sce every 4 cycles, ch3 high 7 cycles per period.
    for (int k = 0; k < 200; k++) begin
      r = NL'($urandom()) & ~NL'(20'h8);
      if ((k % 40) < 7) r[3] = 1'b1;
      if ((k % 40) == 38) cyc(r, (k % 4) == 0, 10, 0, 1, 3);
      else cyc(r, (k % 4) == 0, 10, 0, ($urandom_range(3) == 0), $urandom_range(NL - 1));
    end

    // Latch boundary: 5 events then one coincident with ext latch -> 6; next period starts at 0.
    cyc('0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 10; k++) cyc(NL'(k % 2 == 0), 0, 0, 0, 0, 0);
    cyc(NL'(1), 0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1, 0);
    cyc('0, 0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1, 0);

    // Saturation: 20 events on ch1 -> 15 sat; then 3 events -> 3 no sat.
    for (int k = 0; k < 20; k++) cyc(NL'(2), 0, 0, 0, 0, 0);
    cyc('0, 0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) cyc(NL'(2), 0, 0, 0, 0, 0);
    cyc('0, 0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1, 1);

    // Read/latch collision returns old hold; out-of-range address reads 0 with ack.
    for (int k = 0; k < 5; k++) cyc(NL'(2), 0, 0, 0, 0, 0);
    cyc('0, 0, 0, 1, 1, 1);
    cyc('0, 0, 0, 0, 1, 1);
    cyc('0, 0, 0, 0, 1, 25);
    cyc('0, 0, 0, 0, 1, 31);

    // period 0: 1000 ticks with no auto latch, then enough ext latches to wrap period_num.
    for (int k = 0; k < 1000; k++)
      cyc(NL'($urandom()), 1, 0, 0, ($urandom_range(7) == 0), $urandom_range(31));
    for (int k = 0; k < 260; k++) cyc('0, 1, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1, 0);

    // Reset mid-period after 4 events on ch5, with readback holding nonzero data.
    for (int k = 0; k < 4; k++) cyc(NL'(20'h20), 1, 0, 0, 0, 0);
    cyc('0, 0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1, 5);
    for (int k = 0; k < 4; k++) cyc(NL'(20'h20), 0, 0, 0, 0, 0);
    @(negedge sclk_i); #1;
    rst_n_i = 1'b0;
    zero_inputs();
    #1;
    check_outputs_zero("midreset");
    model_reset();
    #2 rst_n_i = 1'b1;
    @(posedge sclk_i); #1;
    cyc('0, 0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1, 5);
    cyc(NL'(20'h20), 0, 0, 0, 0, 0);
    cyc(NL'(20'h20), 0, 0, 1, 0, 0);
    cyc('0, 0, 0, 0, 1, 5);

    // Randomized traffic with changing (including shrinking) periods and held strobes.
    per = 3;
    for (int k = 0; k < 500; k++) begin
      if ((k % 50) == 0) per = $urandom_range(6, 1);
      cyc(NL'($urandom()), ($urandom_range(1) == 0), per, ($urandom_range(29) == 0),
          ((k % 100) < 10) || ($urandom_range(2) == 0), $urandom_range(31));
    end
    cyc('0, 0, 0, 0, 0, 0);

    @(negedge sclk_i); @(negedge sclk_i);
    chk("status_queue_drained", st_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
